// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared UART definitions
// Purpose: frame width, receiver FSM state encoding and the prescaler
//          divide helper shared by the receive and transmit paths.
package uart_receiver_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Clocks per oversample tick, truncated; never below 1 so the prescaler
  // always has a valid terminal count.
  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    int div;
    div = clk_freq / (baud_rate * oversample);
    if (div < 1) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running prescaler producing a 1-cycle tick
// Purpose: divides clk by DIV and emits a one-cycle enable each period.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset, counter restarts from 0
//   tick   out one-cycle enable every DIV clocks
module baud_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling
// Purpose: deserialises rx frames into bytes with mid-bit sampling and
//          flags frames whose stop bit is sampled low.
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   rx             in   serial line, idle high, asynchronous to clk
//   rx_data        out  last correctly framed byte, LSB first on the line
//   rx_valid       out  one-cycle strobe, rx_data updated
//   framing_error  out  one-cycle strobe, stop bit sampled low
//   rx_busy        out  high from start detect until return to idle
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 w_tick;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  rx_state_t            r_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_framing_error;
  logic                 r_rx_busy;

  baud_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  // Two-flop synchroniser; resets to the idle line level so no false start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_tick_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_framing_error <= 1'b0;
      r_rx_busy       <= 1'b0;
    end else begin
      r_rx_valid      <= 1'b0;
      r_framing_error <= 1'b0;
      case (r_state)
        // Start detection is not tick-gated so the edge is caught within
        // one clock; the tick phase then sets the sampling uncertainty.
        ST_IDLE: begin
          if (!r_rx_s) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
            r_rx_busy  <= 1'b1;
          end
        end
        // Half a bit in: still low means a real start bit, else a glitch.
        ST_START: begin
          if (w_tick) begin
            if (r_tick_cnt == HALF_LAST) begin
              r_tick_cnt <= '0;
              if (!r_rx_s) begin
                r_state   <= ST_DATA;
                r_bit_cnt <= '0;
              end else begin
                r_state   <= ST_IDLE;
                r_rx_busy <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        // LSB arrives first, so shifting in at the MSB and moving right
        // leaves the byte in natural order after the eighth bit.
        ST_DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= ST_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        // Leaving at mid-stop lets a start bit right after the stop bit
        // be seen without any idle gap.
        ST_STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
              r_tick_cnt <= '0;
              r_state    <= ST_IDLE;
              r_rx_busy  <= 1'b0;
              if (r_rx_s) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
              end else begin
                r_framing_error <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_rx_busy <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign framing_error = r_framing_error;
  assign rx_busy       = r_rx_busy;

endmodule
